// File: rtl/csr_pkg.sv
// Shared definitions for the CSR entry streamer: default geometry, FSM
// encoding and the index-width helper.
package csr_pkg;

    localparam int WORD_LENGTH = 8;
    localparam int IMAGE_SIZE  = 28;
    localparam int COL_LENGTH  = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    // Width needed to index 'value' items; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/csr_entry_streamer_if.sv
// Capture bus from the CSR encoder plus the outgoing triplet stream.
// master = the streamer, slave = the encoder/consumer environment.
interface csr_entry_streamer_if #(
    parameter int word_length = csr_pkg::WORD_LENGTH,
    parameter int image_size  = csr_pkg::IMAGE_SIZE,
    parameter int col_length  = csr_pkg::COL_LENGTH
);
    localparam int BUS_W = image_size * image_size * word_length;

    logic                   in_valid;
    logic [BUS_W-1:0]       data_in;
    logic [BUS_W-1:0]       data_in_cols;
    logic [BUS_W-1:0]       data_in_rows;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [word_length-1:0] out_value;
    logic [col_length-1:0]  out_row;
    logic [col_length-1:0]  out_col;
    logic                   out_last;
    logic                   done;

    modport master (
        input  in_valid, data_in, data_in_cols, data_in_rows, out_ready,
        output busy, out_valid, out_value, out_row, out_col, out_last, done
    );

    modport slave (
        output in_valid, data_in, data_in_cols, data_in_rows, out_ready,
        input  busy, out_valid, out_value, out_row, out_col, out_last, done
    );

endinterface

// File: rtl/csr_word_select.sv
// Extracts word[idx] from a flattened bus; out-of-range indices read zero.
module csr_word_select #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 784,
    parameter int IDX_W       = 10
) (
    input  logic [DEPTH*WORD_LENGTH-1:0] bus,
    input  logic [IDX_W-1:0]             idx,
    output logic [WORD_LENGTH-1:0]       word
);

    // NOTE: the default assignment ahead of the loop keeps this purely combinational (no latch).
    always_comb begin
        word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == IDX_W'(i)) word = bus[i*WORD_LENGTH +: WORD_LENGTH];
        end
    end

endmodule

// File: rtl/csr_entry_streamer.sv
// Captures a CSR frame (values, columns, row counts) and replays its non-zero
// entries as (row, col, value) triplets under a valid/ready handshake.
module csr_entry_streamer
    import csr_pkg::*;
#(
    parameter int word_length = WORD_LENGTH,
    parameter int image_size  = IMAGE_SIZE,
    parameter int col_length  = COL_LENGTH
) (
    input  logic                 clk,
    input  logic                 rst,
    csr_entry_streamer_if.master bus
);

    localparam int NUM_ENTRIES = image_size * image_size;
    localparam int K_W         = clog2(NUM_ENTRIES);
    localparam int BUS_W       = NUM_ENTRIES * word_length;
    localparam int ROWS_W      = image_size * word_length;
    localparam logic [K_W-1:0]         K_MAX = K_W'(NUM_ENTRIES - 1);
    localparam logic [word_length-1:0] ONE   = word_length'(1);

    logic [1:0]             state_q, state_d;
    logic [word_length-1:0] r_q, r_d;
    logic [word_length-1:0] cnt_q, cnt_d;
    logic [K_W-1:0]         k_q, k_d;
    logic [BUS_W-1:0]       vals_q, vals_d;
    logic [BUS_W-1:0]       cols_q, cols_d;
    logic [ROWS_W-1:0]      rows_q, rows_d;
    logic [image_size-1:0]  tail_zero_q, tail_zero_d;

    logic [image_size-1:0]  capture_mask;
    logic                   zero_above;
    logic                   tail_zero_r;
    logic                   last_beat;
    logic                   emit;
    logic [word_length-1:0] cur_value, cur_col, row_count;
    logic                   unused_rows;

    // Row-count words past image_size carry no meaning.
    assign unused_rows = ^bus.data_in_rows[BUS_W-1:ROWS_W];

    csr_word_select #(.WORD_LENGTH(word_length), .DEPTH(NUM_ENTRIES), .IDX_W(K_W))
        u_value_sel (.bus(vals_q), .idx(k_q), .word(cur_value));
    csr_word_select #(.WORD_LENGTH(word_length), .DEPTH(NUM_ENTRIES), .IDX_W(K_W))
        u_col_sel (.bus(cols_q), .idx(k_q), .word(cur_col));
    csr_word_select #(.WORD_LENGTH(word_length), .DEPTH(image_size), .IDX_W(word_length))
        u_row_sel (.bus(rows_q), .idx(r_q), .word(row_count));

    // Bit r set when every row after r is empty, so out_last needs no look-ahead scan.
    always_comb begin
        capture_mask = '0;
        zero_above   = 1'b1;
        for (int i = image_size - 1; i >= 0; i--) begin
            capture_mask[i] = zero_above;
            if (bus.data_in_rows[i*word_length +: word_length] != '0) zero_above = 1'b0;
        end
    end

    always_comb begin
        tail_zero_r = 1'b0;
        for (int i = 0; i < image_size; i++) begin
            if (r_q == word_length'(i)) tail_zero_r = tail_zero_q[i];
        end
    end

    assign emit      = (state_q == ST_EMIT);
    assign last_beat = (k_q == K_MAX) || ((cnt_q == ONE) && tail_zero_r);

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        vals_d      = vals_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        tail_zero_d = tail_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    vals_d      = bus.data_in;
                    cols_d      = bus.data_in_cols;
                    rows_d      = bus.data_in_rows[ROWS_W-1:0];
                    tail_zero_d = capture_mask;
                    r_d         = '0;
                    k_d         = '0;
                    cnt_d       = '0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (row_count == '0) begin
                    if (r_q == word_length'(image_size - 1)) state_d = ST_FIN;
                    else r_d = r_q + 1'b1;
                end else begin
                    cnt_d   = row_count;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    k_d   = k_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    // The final beat (clip or trailing empty rows) finishes immediately.
                    if (last_beat) begin
                        state_d = ST_FIN;
                    end else if (cnt_q == ONE) begin
                        r_d     = r_q + 1'b1;
                        state_d = ST_SCAN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: frame buffers are reset too, so an aborted frame can never be replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            vals_q      <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            tail_zero_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            vals_q      <= vals_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            tail_zero_q <= tail_zero_d;
        end
    end

    assign bus.busy      = (state_q == ST_SCAN) || emit;
    assign bus.out_valid = emit;
    assign bus.out_value = emit ? cur_value : '0;
    assign bus.out_row   = emit ? col_length'(r_q) : '0;
    assign bus.out_col   = emit ? col_length'(cur_col) : '0;
    assign bus.out_last  = emit && last_beat;
    assign bus.done      = (state_q == ST_FIN);

endmodule

// File: tb/tb_csr_entry_streamer.sv
// Directed bench for csr_entry_streamer: frames are captured, the expected
// triplets are queued from the frame contents and popped as beats are accepted.
module tb_csr_entry_streamer;
    import csr_pkg::*;

    localparam int W = WORD_LENGTH;
    localparam int N = IMAGE_SIZE;
    localparam int E = N * N;

    typedef struct {
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] value;
        logic       last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst;
    int    checks = 0;
    int    errors = 0;
    beat_t sb[$];

    csr_entry_streamer_if ifc ();

    csr_entry_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_frame();
        ifc.in_valid     = 1'b0;
        ifc.data_in      = '0;
        ifc.data_in_cols = '0;
        ifc.data_in_rows = '0;
    endtask

    task automatic set_entry(input int k, input int value, input int col);
        ifc.data_in[k*W +: W]      = W'(value);
        ifc.data_in_cols[k*W +: W] = W'(col);
    endtask

    task automatic set_row(input int r, input int count);
        ifc.data_in_rows[r*W +: W] = W'(count);
    endtask

    // Reference model: walk row counts in order, clip at the buffer end.
    task automatic build_expected();
        int    k;
        beat_t b;
        k = 0;
        sb.delete();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < int'(ifc.data_in_rows[r*W +: W]); c++) begin
                if (k < E) begin
                    b.row   = 8'(r);
                    b.col   = ifc.data_in_cols[k*W +: W];
                    b.value = ifc.data_in[k*W +: W];
                    b.last  = 1'b0;
                    sb.push_back(b);
                    k++;
                end
            end
        end
        if (sb.size() > 0) begin
            b = sb.pop_back();
            b.last = 1'b1;
            sb.push_back(b);
        end
    endtask

    // Capture the current frame and stream it; cycle numbers are relative to capture.
    task automatic run_frame(input string tag, input bit bp, input int exp_first,
                             input int exp_done, input bit glitch);
        int    cyc, first, done_cyc, accepted, expected_beats;
        beat_t e;
        build_expected();
        expected_beats = sb.size();
        first    = -1;
        done_cyc = -1;
        accepted = 0;
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc <= 1500) begin
            ifc.out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (glitch && cyc == 5) begin
                ifc.in_valid = 1'b1;
                set_row(0, 1);
                set_entry(0, 8'hFF, 1);
            end
            if (glitch && cyc == 6) ifc.in_valid = 1'b0;
            if (ifc.out_valid) begin
                if (first < 0) first = cyc;
                if (sb.size() == 0) begin
                    check({tag, ".extra_beat"}, 32'(ifc.out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    check({tag, ".row"},   32'(ifc.out_row),   32'(e.row));
                    check({tag, ".col"},   32'(ifc.out_col),   32'(e.col));
                    check({tag, ".value"}, 32'(ifc.out_value), 32'(e.value));
                    check({tag, ".last"},  32'(ifc.out_last),  32'(e.last));
                    if (ifc.out_ready) begin
                        void'(sb.pop_front());
                        accepted++;
                    end
                end
            end
            if (ifc.done) begin
                done_cyc = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, ".done_cycle"},  32'(done_cyc), 32'(exp_done));
        check({tag, ".first_valid"}, 32'(first),    32'(exp_first));
        check({tag, ".beats"},       32'(accepted), 32'(expected_beats));
        if (glitch) ifc.in_valid = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        check({tag, ".busy_after"}, 32'(ifc.busy), 32'd0);
        check({tag, ".done_pulse"}, 32'(ifc.done), 32'd0);
    endtask

    initial begin
        int nvalid;

        rst = 1'b1;
        clear_frame();
        ifc.out_ready = 1'b0;
        #12;
        check("reset.busy",      32'(ifc.busy),      32'd0);
        check("reset.out_valid", 32'(ifc.out_valid), 32'd0);
        check("reset.out_last",  32'(ifc.out_last),  32'd0);
        check("reset.done",      32'(ifc.done),      32'd0);
        check("reset.out_value", 32'(ifc.out_value), 32'd0);
        check("reset.out_row",   32'(ifc.out_row),   32'd0);
        check("reset.out_col",   32'(ifc.out_col),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single non-zero entry in row 3.
        clear_frame();
        set_row(3, 1);
        set_entry(0, 8'h5A, 7);
        run_frame("single", 1'b0, 5, 6, 1'b0);

        // Diagonal; row-count word 28 lies beyond the image and must be ignored.
        clear_frame();
        for (int i = 0; i < N; i++) begin
            set_row(i, 1);
            set_entry(i, i + 1, i);
        end
        set_row(N, 9);
        run_frame("diag", 1'b0, 2, 57, 1'b0);

        // Dense row 0 under backpressure.
        clear_frame();
        set_row(0, N);
        for (int i = 0; i < N; i++) set_entry(i, 8'h80 + i, i);
        run_frame("bp", 1'b1, 2, 57, 1'b0);

        // Empty frame; in_valid during SCAN and during done must not capture.
        clear_frame();
        run_frame("empty", 1'b0, -1, 29, 1'b1);

        // Reset asserted while the 5th diagonal beat is presented.
        clear_frame();
        for (int i = 0; i < N; i++) begin
            set_row(i, 1);
            set_entry(i, i + 1, i);
        end
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 100 && nvalid < 5; i++) begin
            if (ifc.out_valid) nvalid++;
            if (nvalid < 5) @(negedge clk);
        end
        check("rst.fifth_beat", 32'(nvalid), 32'd5);
        check("rst.fifth_value", 32'(ifc.out_value), 32'd5);
        rst = 1'b1;
        #1;
        check("rst.busy",      32'(ifc.busy),      32'd0);
        check("rst.out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst.out_value", 32'(ifc.out_value), 32'd0);
        check("rst.out_row",   32'(ifc.out_row),   32'd0);
        check("rst.out_col",   32'(ifc.out_col),   32'd0);
        check("rst.out_last",  32'(ifc.out_last),  32'd0);
        check("rst.done",      32'(ifc.done),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_frame();
        set_row(3, 1);
        set_entry(0, 8'h5A, 7);
        run_frame("restart", 1'b0, 5, 6, 1'b0);

        // Row counts summing to 800: stream clips at entry 783.
        clear_frame();
        for (int r = 0; r < 4; r++) set_row(r, 200);
        for (int k = 0; k < E; k++) set_entry(k, (k & 8'hFF) ^ 8'h3C, k % N);
        run_frame("clip", 1'b0, 2, 789, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_entry_streamer.md
# csr_entry_streamer

Downstream consumer of the CSR encoder. Captures the encoder's three flattened CSR buses (values, column indices, per-row counts) on its `out_valid` pulse and replays the non-zero entries as a serial stream of (row, col, value) triplets under a valid/ready handshake. The sparse-convolution MAC stage sits after it, one entry per accepted beat.

## Interface
- `word_length`, default 8: bits per CSR word (value, column, row-count).
- `image_size`, default 28: image edge length. Max entries = image_size².
- `col_length`, default 8: width of the `out_row` and `out_col` index outputs.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: CSR buses valid this cycle (driven from the encoder `out_valid`).
- `data_in`, input, image_size²·word_length: values. Entry k is at [word_length·k +: word_length].
- `data_in_cols`, input, image_size²·word_length: column index of entry k, same packing.
- `data_in_rows`, input, image_size²·word_length: word r (r < image_size) = non-zero count of row r. Higher words are ignored.
- `busy`, output, 1: a frame is captured and not yet fully streamed.
- `out_valid`, output, 1: a triplet is presented.
- `out_ready`, input, 1: downstream accepts the triplet.
- `out_value`, output, word_length: value of the current entry.
- `out_row`, output, col_length: row index of the current entry.
- `out_col`, output, col_length: column of the current entry (low col_length bits of the column word).
- `out_last`, output, 1: the current entry is the final one of the frame.
- `done`, output, 1: one-cycle pulse when the frame completes.

## Operation
- States: IDLE, SCAN, EMIT, FIN.
- **IDLE**
  - On `in_valid`, register all three buses.
  - Clear r (row), k (entry index) and cnt.
  - Go to SCAN.
- **SCAN**
  - If rows[r] = 0 and r < image_size−1: increment r and stay in SCAN. One row is skipped per cycle.
  - If rows[r] = 0 and r = image_size−1: go to FIN.
  - Otherwise: cnt ← rows[r], go to EMIT.
- **EMIT**
  - `out_valid` = 1; value[k], cols[k] and r are driven combinationally from registers.
  - On `out_valid && out_ready`: k ← k+1 and cnt ← cnt−1.
  - When cnt = 1 at acceptance: if r = image_size−1, go to FIN; else r ← r+1 and go to SCAN.
  - When k = image_size²−1 at acceptance: go to FIN. This clip guards against row counts that sum past the buffer.
- `out_last` = EMIT and (k = image_size²−1, or cnt = 1 with all remaining rows[r+1..] = 0). The remaining-rows term is computed from a registered suffix-zero mask built at capture.
- **FIN**: `done` = 1 for exactly one cycle, then go to IDLE.
- `in_valid` is ignored outside IDLE; the captured frame is never overwritten mid-stream.
- Holding `out_ready` low stalls EMIT indefinitely; all outputs stay stable while `out_valid` is high and the beat is not accepted.
- All counters use unsigned arithmetic. k is ⌈log2(image_size²)⌉ bits; r and cnt are word_length bits.

## Timing
- Reset (asynchronous, any state): state = IDLE, r = k = cnt = 0, registered buses cleared.
- Output values while in reset:
  - `busy` = 0, `out_valid` = 0, `out_last` = 0, `done` = 0.
  - `out_value` = 0, `out_row` = 0, `out_col` = 0.
- `busy` = 1 in SCAN and EMIT; 0 in IDLE and FIN.
- Capture edge at cycle C. Frame whose first non-empty row is r0: first `out_valid` in cycle C+2+r0.
- With `out_ready` held high, one entry per cycle within a row. Each row transition costs 1 SCAN cycle plus 1 per empty row skipped.
- `done` is asserted the cycle after the accepted `out_last` beat. An all-zero frame produces `done` at cycle C+1+image_size with no beats.
- `in_valid` in the same cycle as `done` is ignored. A new capture is possible from the following cycle.

## Structure
- Shared package `csr_pkg` holds:
  - the default localparams WORD_LENGTH, IMAGE_SIZE, COL_LENGTH;
  - the state encoding IDLE/SCAN/EMIT/FIN;
  - the index-width function clog2.
- One sub-module `csr_word_select`: parameterised word_length/depth mux that extracts word[idx] from a flattened bus. Instantiated three times (value, col, row-count).

## Test plan
- **Single entry.** Capture a frame with one non-zero (value 0x5A, row 3, col 7); `out_ready` = 1. Expect:
  - exactly one beat (row=3, col=7, value=0x5A, `out_last` = 1) at C+5;
  - `done` at C+6;
  - `busy` low afterwards.
- **Diagonal.** Frame value(i,i) = i+1 for i = 0..27. Expect 28 beats, each separated by one SCAN cycle, with row = col = i and `out_last` only on i = 27.
- **Backpressure.** Dense row 0 with 28 entries; toggle `out_ready` 1,0,0,1,… Expect:
  - every beat held stable while `out_ready` = 0;
  - values in order, no duplicates or drops;
  - k ends at 28.
- **Empty and ignored frame.** Capture an all-zero frame. Expect no `out_valid` and `done` at C+29. A second `in_valid` pulse during SCAN is ignored.
- **Reset mid-stream.** Assert `rst` on the 5th beat of the diagonal frame. Expect all outputs 0 immediately, state IDLE, and a clean restart on the next `in_valid`.
- **Overflow clip.** Row counts sum to 800. Expect streaming to stop at k = 783 with `out_last` = 1 on that beat, followed by `done`.
